// File: rtl/fifo_drain_ctrl.sv
// rtl/fifo_drain_ctrl.sv - read-side drain controller: credit-gated FIFO reads into a skid buffer feeding a valid/ready stream
module fifo_drain_ctrl #(
    parameter int WIDTH      = 8,
    parameter int SKID_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             rd_clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             empty,
    output logic             rd_EN,
    input  logic [WIDTH-1:0] data_out,
    input  logic             Dout_valid,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             idle,
    output logic [CNT_W-1:0] xfer_cnt,
    output logic             err
);

    localparam int PW = $clog2(SKID_DEPTH);
    localparam int OW = PW + 1;
    localparam logic [OW-1:0] DEPTH_O = SKID_DEPTH[OW-1:0];
    localparam logic [OW:0]   DEPTH_E = SKID_DEPTH[OW:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic             inflight;
    logic [OW-1:0]    occ;
    logic [PW-1:0]    wptr, rptr;
    logic [WIDTH-1:0] mem [SKID_DEPTH];
    logic             pop, push, drop, full;

    assign m_valid = (occ != '0);
    assign m_data  = mem[rptr];
    assign idle    = (state == IDLE);

    always_comb begin
        pop   = m_valid && m_ready;
        full  = (occ == DEPTH_O);
        // a word with no matching read, or one arriving into a full skid, is lost
        drop  = Dout_valid && (!inflight || (full && !pop));
        push  = Dout_valid && !drop;
        // credit counts the in-flight word but not a same-cycle pop
        rd_EN = (state == RUN) && !empty &&
                (({1'b0, occ} + {{OW{1'b0}}, inflight}) < DEPTH_E);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (enable) state_nxt = RUN;
            RUN:  if (!enable) state_nxt = STOP;
            STOP: begin
                if (enable)
                    state_nxt = RUN;
                else if (!inflight && (occ == '0))
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            inflight <= 1'b0;
            occ      <= '0;
            wptr     <= '0;
            rptr     <= '0;
            xfer_cnt <= '0;
            err      <= 1'b0;
            for (int i = 0; i < SKID_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            inflight <= rd_EN;
            if (push) begin
                mem[wptr] <= data_out;
                wptr      <= wptr + 1'b1;
            end
            if (pop) begin
                rptr     <= rptr + 1'b1;
                xfer_cnt <= xfer_cnt + 1'b1;
            end
            if (push && !pop)
                occ <= occ + 1'b1;
            else if (!push && pop)
                occ <= occ - 1'b1;
            if (drop)
                err <= 1'b1;
        end
    end

endmodule

// File: doc/fifo_drain_ctrl.md
# fifo_drain_ctrl

Read-side drain controller for the asynchronous FIFO. It runs in the read clock domain and issues `rd_EN` only when the FIFO is non-empty and local buffering can absorb the result. It captures `data_out`/`Dout_valid` into a small skid buffer and presents the words to downstream logic on a valid/ready stream. It replaces ad-hoc random read enables with a flow-controlled consumer that never drops a word and sustains one word per cycle.

## Interface
- `WIDTH`, 8, data word width; must match the FIFO `WIDTH`.
- `SKID_DEPTH`, 4, skid buffer entries; power of 2, at least 3 (3 is the minimum for full throughput).
- `CNT_W`, 16, width of the transferred-word counter.

Ports (one clock; reset is asynchronous and active-high):
- `rd_clk` in 1: read-domain clock; all state is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: level; 1 = drain the FIFO, 0 = stop issuing reads.
- `empty` in 1: FIFO empty flag, synchronous to `rd_clk`.
- `rd_EN` out 1: FIFO read request.
- `data_out` in WIDTH: FIFO read data.
- `Dout_valid` in 1: FIFO read data valid.
- `m_data` out WIDTH: stream data, taken from the skid head.
- `m_valid` out 1: stream valid.
- `m_ready` in 1: stream ready.
- `idle` out 1: controller is in IDLE.
- `xfer_cnt` out CNT_W: count of completed stream transfers; wraps.
- `err` out 1: sticky protocol error.

## Operation
- FIFO contract:
  - A read is accepted in cycle N when `rd_EN` and `!empty`.
  - `Dout_valid` and `data_out` are valid in cycle N+1.
  - There is exactly one data word per accepted read.
- `inflight` is a 1-bit register, set to (`rd_EN` and `!empty`) every cycle.
- `occ` is the skid occupancy, 0..SKID_DEPTH, width clog2(SKID_DEPTH)+1.
- `rd_EN` is combinational: (state == RUN) and `!empty` and (`occ` + `inflight` < SKID_DEPTH).
  - The credit check uses the current `occ` and gives no credit for a same-cycle pop.
- Skid buffer:
  - Circular buffer with write and read pointers of log2(SKID_DEPTH) bits; pointers wrap naturally.
  - Push when `Dout_valid`; pop when `m_valid` and `m_ready`.
  - Push and pop in the same cycle leave `occ` unchanged; both pointers advance.
  - There is no bypass path: a word pushed into an empty skid appears on `m_data` the next cycle.
- `m_valid` = (`occ` != 0). `m_data` = buffer entry at the read pointer.
  - `m_data` holds its value while `m_valid` and `!m_ready`.
- `xfer_cnt` increments by 1 on each pop and wraps from 2^CNT_W−1 to 0.
- `err` is set, and held until `rst`, when either:
  - `Dout_valid` arrives while `inflight` == 0 (the word is dropped), or
  - `Dout_valid` arrives with `occ` == SKID_DEPTH and no pop that cycle (the word is dropped and pointers are unchanged).
- FSM:
  - IDLE → RUN when `enable`.
  - RUN → STOP when `!enable`.
  - STOP → RUN when `enable`.
  - STOP → IDLE when `inflight` == 0 and `occ` == 0.
  - In STOP no reads are issued, the in-flight word is captured, and the skid continues draining to the stream.
  - `idle` = (state == IDLE).
- Reset values: state IDLE, `rd_EN` 0, `m_valid` 0, `m_data` 0, `occ` 0, pointers 0, `inflight` 0, `xfer_cnt` 0, `err` 0, `idle` 1.
- Reset mid-operation: skid contents and any in-flight read are discarded. The FIFO must be reset in the same window; otherwise a stray `Dout_valid` sets `err`.

## Timing
- The first `rd_EN` is in the first cycle in RUN with `!empty`. With `enable` high at reset release, that is cycle 1 after the IDLE→RUN edge.
- Latency from `rd_EN` accepted in cycle N to `m_valid` is cycle N+2; `data_out` is captured at the end of N+1.
- Throughput is 1 word/cycle with `m_ready` held high, `!empty`, and SKID_DEPTH ≥ 3. Steady state is `occ` = 1 and `inflight` = 1.
- With `m_ready` low, `rd_EN` deasserts once `occ` + `inflight` reaches SKID_DEPTH. At most SKID_DEPTH words are buffered, and none are lost.
- When `empty` rises, `rd_EN` drops the same cycle (combinational). A `rd_EN` pulse with `empty` = 1 is not counted as in flight.
- `enable` falling in cycle N gives `rd_EN` = 0 in cycle N+1 (the FSM is registered). `idle` rises one cycle after the last pop with `inflight` == 0.

## Test plan
- FIFO preloaded with 10, 20, 30; `enable` = 1; `m_ready` = 1 → `rd_EN` high for 3 consecutive cycles, `m_data` 10/20/30 on consecutive cycles starting 2 cycles after the first read, `xfer_cnt` = 3, `err` = 0, `idle` returns to 1 after `enable` drops.
- 8 words preloaded, `m_ready` = 0 → `rd_EN` issues exactly 4 reads then holds 0 and `occ` = 4; raising `m_ready` streams all 8 words in order with no gaps after the restart.
- FIFO fed at random by the 100 MHz writer, `m_ready` random 50%, 40 words → stream order equals write order, `err` = 0, `xfer_cnt` = 40.
- `enable` dropped while 1 read is in flight and `occ` = 2 → state STOP, no further `rd_EN`, 3 words delivered, then `idle` = 1.
- `Dout_valid` forced for 1 cycle with no read outstanding → `err` = 1 sticky, `occ` unchanged; `rst` pulse mid-stream → all outputs at reset values asynchronously, `xfer_cnt` = 0.
- `xfer_cnt` preset near wrap with CNT_W = 4: 17 transfers → `xfer_cnt` = 1.
